// File: rtl/rvseed_defines.sv
// Shared LSU definitions: opcode encodings, access size codes and FSM states.
package rvseed_defines;

  localparam int LSU_OP_WIDTH = 4;

  localparam logic [LSU_OP_WIDTH-1:0] LSU_LB  = 4'b0000;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_LH  = 4'b0001;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_LW  = 4'b0010;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_LD  = 4'b0011;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_LBU = 4'b0100;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_LHU = 4'b0101;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_LWU = 4'b0110;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_SB  = 4'b1000;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_SH  = 4'b1001;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_SW  = 4'b1010;
  localparam logic [LSU_OP_WIDTH-1:0] LSU_SD  = 4'b1011;

  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;
  localparam logic [1:0] LSU_SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Anything outside the legal set behaves as a plain doubleword load.
  function automatic logic [LSU_OP_WIDTH-1:0] lsu_norm_op(input logic [LSU_OP_WIDTH-1:0] op);
    case (op)
      LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
      LSU_SB, LSU_SH, LSU_SW, LSU_SD: return op;
      default:                        return LSU_LD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Byte-lane helper for the LSU: store mask/lane placement and load shift/truncate/extend.
module lsu_ext
  import rvseed_defines::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = 8,
  parameter int OFF_W     = $clog2(MEM_BYTES)
) (
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  input  logic [OFF_W-1:0]     off,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata,
  output logic [MEM_BYTES-1:0] wmask,
  output logic [XLEN-1:0]      wdata_lane,
  output logic [XLEN-1:0]      rdata_ext,
  output logic                 misaligned
);

  logic [OFF_W-1:0] low_bits;
  logic [OFF_W-1:0] off_al;
  logic [XLEN-1:0]  rshift;

  always_comb begin
    low_bits   = OFF_W'((32'd1 << size) - 32'd1);
    off_al     = off & ~low_bits;
    misaligned = (off & low_bits) != '0;
    wmask      = MEM_BYTES'((32'd1 << (32'd1 << size)) - 32'd1) << off_al;
    wdata_lane = wdata << {off_al, 3'b000};
    rshift     = rdata >> {off_al, 3'b000};
    case (size)
      LSU_SZ_B: rdata_ext = {{(XLEN-8){~is_unsigned & rshift[7]}}, rshift[7:0]};
      LSU_SZ_H: rdata_ext = {{(XLEN-16){~is_unsigned & rshift[15]}}, rshift[15:0]};
      LSU_SZ_W: rdata_ext = {{(XLEN-32){~is_unsigned & rshift[31]}}, rshift[31:0]};
      default:  rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one handshaked data-memory access per request.
// Build option LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module lsu
  import rvseed_defines::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LSU_OP_WIDTH-1:0] req_op,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_wen,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [MEM_BYTES-1:0]    mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_rdata,
  output logic                    resp_err
);
  // state | meaning
  // IDLE  | ready for a new request
  // REQ   | memory request presented, waiting for mem_ready
  // WAIT  | load accepted by memory, waiting for mem_rvalid
  // RESP  | result presented to writeback, waiting for resp_ready

  localparam int OFF_W = $clog2(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e state_q, state_d;
  logic [LSU_OP_WIDTH-1:0] op_q, op_d, req_op_n;
  logic [OFF_W-1:0] off_q, off_d, ext_off;
  logic req_ready_q, req_ready_d;
  logic mem_valid_q, mem_valid_d, mem_wen_q, mem_wen_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [MEM_BYTES-1:0] mem_wmask_q, mem_wmask_d, ext_wmask;
  logic resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0] ext_size;
  logic ext_uns, ext_misaligned;
  logic [XLEN-1:0] ext_wdata, ext_rdata;

  // The lane helper sees the incoming request while idle, the latched one afterwards.
  always_comb begin
    req_op_n = lsu_norm_op(req_op);
    if (state_q == ST_IDLE) begin
      ext_size = req_op_n[1:0];
      ext_uns  = req_op_n[2];
      ext_off  = req_addr[OFF_W-1:0];
    end else begin
      ext_size = op_q[1:0];
      ext_uns  = op_q[2];
      ext_off  = off_q;
    end
  end

  lsu_ext #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES), .OFF_W(OFF_W)) u_ext (
    .size        (ext_size),
    .is_unsigned (ext_uns),
    .off         (ext_off),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .wmask       (ext_wmask),
    .wdata_lane  (ext_wdata),
    .rdata_ext   (ext_rdata),
    .misaligned  (ext_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    req_ready_d  = req_ready_q;
    mem_valid_d  = mem_valid_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = req_op_n;
          off_d       = req_addr[OFF_W-1:0];
          req_ready_d = 1'b0;
          if (TRAP_EN && ext_misaligned) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ;
            mem_valid_d = 1'b1;
            mem_wen_d   = req_op_n[3];
            mem_addr_d  = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_d = req_op_n[3] ? ext_wdata : '0;
            mem_wmask_d = ext_wmask;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          resp_err_d  = 1'b0;
          if (op_q[3]) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else if (mem_rvalid) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = ext_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ext_rdata;
        end
      end
      default: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
